biquad_coef_bank: RTL and testbench
===================================

Name: biquad_coef_bank

Overview:
- Double-buffered coefficient register bank sitting directly upstream of the biquad section; drives its a11, a12, b10, b11 and b12 inputs.
- Host writes a shadow set, then requests a commit. The active set swaps atomically on a sample boundary (filter valid strobe), so the filter never mixes old and new coefficients within one sample.
- Also clamps the unrepresentable most-negative code, which the section's sign-magnitude conversion would turn into zero.

Parameters:
- COEFWIDTH, 16, coefficient width, signed fractional 2's complement; matches the filter's COEFWIDTH.
- IDLE_TIMEOUT, 255, clocks with no valid after which a pending commit is forced; must be >= 1.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- wr_en  in  1  shadow write strobe
- wr_addr  in  3  write address
- wr_data  in  COEFWIDTH  write data
- rd_addr  in  3  readback address
- rd_data  out  COEFWIDTH  registered readback data
- commit  in  1  request shadow->active swap, single-cycle pulse
- valid  in  1  filter sample strobe, same net as the filter's valid
- pending  out  1  commit requested, swap not yet done
- commit_done  out  1  one-cycle pulse on the cycle after the swap
- clamp_err  out  1  sticky: a most-negative code was written and clamped
- a11, a12, b10, b11, b12  out  COEFWIDTH each  active coefficients to the filter

Behaviour:
- Reset: nreset, asynchronous, active-low; clock clk. All shadow and active registers = 0; rd_data, pending, commit_done, clamp_err = 0; idle counter = 0.
- Address map:
  - 0 = b10, 1 = b11, 2 = b12, 3 = a11, 4 = a12.
  - 5 = status, read-only: bit0 pending, bit1 clamp_err, others 0.
  - 6 and 7 read 0.
  - Writes to 5–7 are ignored, except that a write to 5 with wr_data[1]=1 clears clamp_err.
- Shadow write: on a clk edge with wr_en=1 and wr_addr in 0–4, shadow[wr_addr] <= wr_data.
  - If wr_data = 1 followed by COEFWIDTH-1 zeros, store 1 followed by COEFWIDTH-2 zeros and a 1 instead, and set clamp_err.
- Readback: rd_data <= value selected by rd_addr. Addresses 0–4 return the active (not shadow) value. One-cycle latency.
- Commit FSM states:
  - IDLE: commit=1 -> PEND, pending=1, idle counter cleared.
  - PEND, valid=1: swap; active <= shadow for all five coefficients in the same edge -> IDLE. Because the swap edge is also the filter's capture edge, the new set applies from the next valid onward.
  - PEND, valid=0: increment idle counter. When the counter reaches IDLE_TIMEOUT-1, swap on that edge -> IDLE.
  - commit in PEND: ignored; the counter is not restarted.
  - commit_done = 1 on the cycle after any swap.
- Simultaneous write and swap: the swap copies the pre-write shadow value; the write lands in shadow only and needs a further commit.
- Simultaneous commit and swap edge: cannot occur, since commit is ignored in PEND.
- Active outputs change only on a swap edge and are registered (no combinational path from wr_*).
- Reset mid-PEND: the swap is abandoned, active returns to 0, pending = 0.
- Counter width: clog2(IDLE_TIMEOUT+1); no wrap is possible because the FSM leaves PEND at the terminal count.

Test Plan:
- Reset, then write b10=16'h4000 and commit, valid held 0 -> b10 stays 0, pending=1. Pulse valid at cycle 10 -> b10=16'h4000 after that edge; commit_done high one cycle later; pending=0.
- Write all five addresses (0x1000, 0x2000, 0x3000, 0xE000, 0x0800), commit, valid every 4 clocks -> all five active outputs change on the same edge, the first valid edge after commit. Readback of addr 0–4 matches.
- Write 16'h8000 to addr 3 -> shadow holds 16'h8001, clamp_err=1, status readback = 2'b10. Write addr 5 with data 16'h0002 -> clamp_err=0.
- Commit with valid never asserted, IDLE_TIMEOUT=255 -> swap occurs exactly 255 clocks after the commit edge; commit_done asserted the next clock.
- In PEND, write addr 1 = 0x7FFF on the same edge as valid -> active b11 = old shadow value. A second commit plus valid -> b11 = 0x7FFF.
- Assert nreset mid-PEND -> all outputs 0 immediately (asynchronous). After release, valid pulses cause no swap; pending=0.

Source files
------------

// File: rtl/biquad_coef_bank_if.sv
// Host-side register bus for biquad_coef_bank.
//   wr_en/wr_addr/wr_data : shadow write strobe, address, data
//   rd_addr/rd_data       : readback address, registered readback data
//   commit                : request shadow->active swap (one-cycle pulse)
//   pending               : commit requested, swap not yet done
//   commit_done           : one-cycle pulse on the cycle after a swap
//   clamp_err             : sticky most-negative-code clamp flag
interface biquad_coef_bank_if #(
  parameter int COEFWIDTH = 16
);
  logic                 wr_en;
  logic [2:0]           wr_addr;
  logic [COEFWIDTH-1:0] wr_data;
  logic [2:0]           rd_addr;
  logic [COEFWIDTH-1:0] rd_data;
  logic                 commit;
  logic                 pending;
  logic                 commit_done;
  logic                 clamp_err;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, commit,
    input  rd_data, pending, commit_done, clamp_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, commit,
    output rd_data, pending, commit_done, clamp_err
  );
endinterface

// File: rtl/biquad_coef_bank.sv
// Double-buffered coefficient bank feeding a biquad section.
// The host writes a shadow set and requests a commit; the active set is
// swapped in one edge on the next filter valid strobe (or after
// IDLE_TIMEOUT clocks without valid), so a sample never sees a mix of
// old and new coefficients. The most-negative code is clamped on write.
// Ports:
//   clk, nreset         : clock, asynchronous active-low reset
//   bus                 : host register bus (slave side)
//   valid               : filter sample strobe
//   a11,a12,b10,b11,b12 : active coefficients to the filter
module biquad_coef_bank #(
  parameter int COEFWIDTH    = 16,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 nreset,
  biquad_coef_bank_if.slave    bus,
  input  logic                 valid,
  output logic [COEFWIDTH-1:0] a11,
  output logic [COEFWIDTH-1:0] a12,
  output logic [COEFWIDTH-1:0] b10,
  output logic [COEFWIDTH-1:0] b11,
  output logic [COEFWIDTH-1:0] b12
);

  localparam int CW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [COEFWIDTH-1:0] MOST_NEG = {1'b1, {(COEFWIDTH-1){1'b0}}};
  localparam logic [COEFWIDTH-1:0] CLAMPED  = {1'b1, {(COEFWIDTH-2){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_PEND} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_idle_cnt;
  logic                 r_pending;
  logic                 r_commit_done;
  logic                 r_clamp_err;
  logic [COEFWIDTH-1:0] r_rd_data;
  // index order matches the address map: b10, b11, b12, a11, a12
  logic [COEFWIDTH-1:0] r_shadow [5];
  logic [COEFWIDTH-1:0] r_active [5];

  logic                 w_swap;
  logic                 w_wr_coef;
  logic                 w_is_most_neg;
  logic [COEFWIDTH-1:0] w_wdata;

  assign w_swap        = (r_state == S_PEND) &&
                         (valid || (r_idle_cnt == CW'(IDLE_TIMEOUT - 1)));
  assign w_wr_coef     = bus.wr_en && (bus.wr_addr < 3'd5);
  assign w_is_most_neg = (bus.wr_data == MOST_NEG);
  assign w_wdata       = w_is_most_neg ? CLAMPED : bus.wr_data;

  // Commit FSM: pending/commit_done are registered outputs of this block.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state       <= S_IDLE;
      r_idle_cnt    <= '0;
      r_pending     <= 1'b0;
      r_commit_done <= 1'b0;
    end else begin
      r_commit_done <= w_swap;
      case (r_state)
        S_IDLE: begin
          if (bus.commit) begin
            r_state    <= S_PEND;
            r_pending  <= 1'b1;
            r_idle_cnt <= '0;
          end
        end
        S_PEND: begin
          // commit is ignored here; the idle count keeps running
          if (w_swap) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
          end else begin
            r_idle_cnt <= r_idle_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Shadow/active registers. The swap reads r_shadow before any write on
  // the same edge lands, so a coincident write stays in shadow only.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < 5; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (w_wr_coef && (bus.wr_addr == 3'(i)))
          r_shadow[i] <= w_wdata;
      end
      if (w_swap)
        r_active <= r_shadow;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_clamp_err <= 1'b0;
    end else if (w_wr_coef && w_is_most_neg) begin
      r_clamp_err <= 1'b1;
    end else if (bus.wr_en && (bus.wr_addr == 3'd5) && bus.wr_data[1]) begin
      r_clamp_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_rd_data <= '0;
    end else begin
      case (bus.rd_addr)
        3'd0:    r_rd_data <= r_active[0];
        3'd1:    r_rd_data <= r_active[1];
        3'd2:    r_rd_data <= r_active[2];
        3'd3:    r_rd_data <= r_active[3];
        3'd4:    r_rd_data <= r_active[4];
        3'd5:    r_rd_data <= {{(COEFWIDTH-2){1'b0}}, r_clamp_err, r_pending};
        default: r_rd_data <= '0;
      endcase
    end
  end

  assign b10 = r_active[0];
  assign b11 = r_active[1];
  assign b12 = r_active[2];
  assign a11 = r_active[3];
  assign a12 = r_active[4];

  assign bus.rd_data     = r_rd_data;
  assign bus.pending     = r_pending;
  assign bus.commit_done = r_commit_done;
  assign bus.clamp_err   = r_clamp_err;

endmodule

// File: tb/tb_biquad_coef_bank.sv
// Bench for biquad_coef_bank: directed stimulus, a cycle-level behavioural
// model checked against every output each cycle, and literal spot checks.
module tb_biquad_coef_bank;

  localparam int CWID = 16;
  localparam int TMO  = 255;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic valid = 1'b0;
  logic [CWID-1:0] a11, a12, b10, b11, b12;

  biquad_coef_bank_if #(.COEFWIDTH(CWID)) bus ();

  biquad_coef_bank #(.COEFWIDTH(CWID), .IDLE_TIMEOUT(TMO)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus),
    .valid  (valid),
    .a11    (a11),
    .a12    (a12),
    .b10    (b10),
    .b11    (b11),
    .b12    (b12)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Coefficients indexed by address 0..4 (b10,b11,b12,a11,a12).
  logic [CWID-1:0] m_shadow [5];
  logic [CWID-1:0] m_active [5];
  logic [CWID-1:0] m_rd;
  bit m_pend, m_done, m_clamp;
  int m_cyc, m_commit_cyc;

  initial begin
    for (int i = 0; i < 5; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
    m_rd = '0; m_pend = 0; m_done = 0; m_clamp = 0; m_cyc = 0; m_commit_cyc = 0;
  end

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 5; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
      m_rd = '0; m_pend = 0; m_done = 0; m_clamp = 0;
    end else begin
      logic [CWID-1:0] rd_next;
      bit swap;
      int a;
      m_cyc++;
      a = int'(bus.rd_addr);
      if (a < 5)       rd_next = m_active[a];
      else if (a == 5) rd_next = CWID'(2 * int'(m_clamp) + int'(m_pend));
      else             rd_next = '0;
      // swap on a sample strobe or once TMO clocks have passed since commit
      swap = m_pend && (valid || (m_cyc - m_commit_cyc == TMO));
      if (swap) begin
        for (int i = 0; i < 5; i++) m_active[i] = m_shadow[i];
        m_pend = 0;
      end else if (!m_pend && bus.commit) begin
        m_pend = 1;
        m_commit_cyc = m_cyc;
      end
      m_done = swap;
      a = int'(bus.wr_addr);
      if (bus.wr_en && a < 5) begin
        if (bus.wr_data == 16'h8000) begin
          m_shadow[a] = 16'h8001;
          m_clamp = 1;
        end else begin
          m_shadow[a] = bus.wr_data;
        end
      end else if (bus.wr_en && a == 5 && bus.wr_data[1]) begin
        m_clamp = 0;
      end
      m_rd = rd_next;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("cmp_b10", 32'(b10), 32'(m_active[0]));
    chk("cmp_b11", 32'(b11), 32'(m_active[1]));
    chk("cmp_b12", 32'(b12), 32'(m_active[2]));
    chk("cmp_a11", 32'(a11), 32'(m_active[3]));
    chk("cmp_a12", 32'(a12), 32'(m_active[4]));
    chk("cmp_rd_data", 32'(bus.rd_data), 32'(m_rd));
    chk("cmp_pending", 32'(bus.pending), 32'(m_pend));
    chk("cmp_commit_done", 32'(bus.commit_done), 32'(m_done));
    chk("cmp_clamp_err", 32'(bus.clamp_err), 32'(m_clamp));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [CWID-1:0] data);
    bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
  endtask

  task automatic pulse_valid();
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CWID-1:0] vals [5];
    vals[0] = 16'h1000; vals[1] = 16'h2000; vals[2] = 16'h3000;
    vals[3] = 16'hE000; vals[4] = 16'h0800;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_addr = '0; bus.commit = 1'b0;

    // reset
    repeat (3) tick();
    nreset = 1'b1;
    tick();
    chk("reset_b10", 32'(b10), 32'h0);
    chk("reset_pending", 32'(bus.pending), 32'h0);

    // single coefficient, commit waits for valid
    wr(3'd0, 16'h4000);
    do_commit();
    repeat (8) tick();
    chk("pend_b10_held", 32'(b10), 32'h0);
    chk("pend_flag", 32'(bus.pending), 32'h1);
    pulse_valid();
    chk("swap_b10", 32'(b10), 32'h4000);
    chk("swap_pending_clr", 32'(bus.pending), 32'h0);
    chk("swap_done_pulse", 32'(bus.commit_done), 32'h1);
    tick();
    chk("done_one_cycle", 32'(bus.commit_done), 32'h0);

    // all five, valid every 4 clocks
    for (int i = 0; i < 5; i++) wr(3'(i), vals[i]);
    do_commit();
    for (int i = 0; i < 12; i++) begin
      valid = (i % 4 == 3);
      tick();
      if (i == 2) chk("multi_before", 32'(a11), 32'h0);
      if (i == 3) begin
        chk("multi_b10", 32'(b10), 32'h1000);
        chk("multi_a11", 32'(a11), 32'hE000);
        chk("multi_a12", 32'(a12), 32'h0800);
      end
    end
    valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.rd_addr = 3'(i);
      tick();
      chk("readback", 32'(bus.rd_data), 32'(vals[i]));
    end
    bus.rd_addr = 3'd6;
    tick();
    chk("readback_addr6", 32'(bus.rd_data), 32'h0);

    // most-negative clamp, status and clear
    wr(3'd3, 16'h8000);
    chk("clamp_set", 32'(bus.clamp_err), 32'h1);
    bus.rd_addr = 3'd5;
    tick();
    chk("status_clamp", 32'(bus.rd_data), 32'h2);
    wr(3'd5, 16'h0002);
    chk("clamp_clear", 32'(bus.clamp_err), 32'h0);
    do_commit();
    tick();
    chk("status_pending", 32'(bus.rd_data), 32'h1);
    pulse_valid();
    chk("clamp_value", 32'(a11), 32'h8001);

    // idle timeout: swap exactly TMO clocks after the commit edge
    wr(3'd4, 16'h1234);
    do_commit();
    repeat (TMO - 1) tick();
    chk("tmo_still_pend", 32'(bus.pending), 32'h1);
    chk("tmo_a12_held", 32'(a12), 32'h0800);
    tick();
    chk("tmo_a12_swapped", 32'(a12), 32'h1234);
    chk("tmo_done", 32'(bus.commit_done), 32'h1);
    chk("tmo_pend_clr", 32'(bus.pending), 32'h0);

    // write on the swap edge stays in shadow
    wr(3'd1, 16'h0100);
    do_commit();
    repeat (2) tick();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 16'h7FFF; valid = 1'b1;
    tick();
    bus.wr_en = 1'b0; valid = 1'b0;
    chk("coinc_b11_old", 32'(b11), 32'h0100);
    do_commit();
    pulse_valid();
    chk("coinc_b11_new", 32'(b11), 32'h7FFF);

    // asynchronous reset mid-PEND abandons the swap
    wr(3'd2, 16'h5555);
    do_commit();
    tick();
    #2 nreset = 1'b0;
    #1;
    chk("arst_b10", 32'(b10), 32'h0);
    chk("arst_b11", 32'(b11), 32'h0);
    chk("arst_a12", 32'(a12), 32'h0);
    chk("arst_pending", 32'(bus.pending), 32'h0);
    tick();
    #3 nreset = 1'b1;
    tick();
    repeat (3) begin pulse_valid(); tick(); end
    chk("arst_no_swap_b12", 32'(b12), 32'h0);
    chk("arst_no_pending", 32'(bus.pending), 32'h0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
